inst_encoder: RTL

- Converts decoded instruction fields (operation select, register numbers, shift amount, immediate or offset) into 32-bit LEGv8 instruction words.
- It is the inverse of the main control decoder: it feeds the instruction-memory loader and self-test program generator with valid/ready streams on both sides.
- It keeps a running word address for the instruction-memory write port and flags illegal or out-of-range requests.

---
 rtl/inst_encoder.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// LEGv8 instruction encoder.
// Turns decoded instruction fields into 32-bit instruction words through one
// valid/ready output register. Each emitted word carries the word address it
// should be written to. A request with an illegal op or an out-of-range
// immediate is consumed but not emitted; it raises a one-cycle error pulse
// instead.
module inst_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [5:0]        in_shamt,
    input  logic [25:0]       in_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_valid,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_RANGE   = 2'b10
    } err_e;

    // R-format and D-format opcodes (11 bits)
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_ADDS = 11'b10101011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ANDS = 11'b11101010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_EOR  = 11'b11001010000;
    localparam logic [10:0] OPC_LSR  = 11'b11010011010;
    localparam logic [10:0] OPC_LSL  = 11'b11010011011;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    // I-format opcodes (10 bits)
    localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OPC_ANDI  = 10'b1001001000;
    localparam logic [9:0]  OPC_ORRI  = 10'b1011001000;
    localparam logic [9:0]  OPC_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OPC_EORI  = 10'b1101001000;
    localparam logic [9:0]  OPC_ADDIS = 10'b1011000100;
    localparam logic [9:0]  OPC_SUBIS = 10'b1111000100;
    localparam logic [9:0]  OPC_ANDIS = 10'b1111001000;
    // B and CB opcodes
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ = 8'b10110101;

    function automatic logic [31:0] enc_r(input logic [10:0] opc, input logic [4:0] rm,
                                          input logic [5:0] sh, input logic [4:0] rn,
                                          input logic [4:0] rd);
        return {opc, rm, sh, rn, rd};
    endfunction

    function automatic logic [31:0] enc_i(input logic [9:0] opc, input logic [11:0] imm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {opc, imm, rn, rd};
    endfunction

    function automatic logic [31:0] enc_d(input logic [10:0] opc, input logic [8:0] ofs,
                                          input logic [4:0] rn, input logic [4:0] rt);
        return {opc, ofs, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] enc_cb(input logic [7:0] opc, input logic [18:0] ofs,
                                           input logic [4:0] rt);
        return {opc, ofs, rt};
    endfunction

    logic              r_out_valid;
    logic [31:0]       r_out_inst;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_err_valid;
    logic [1:0]        r_err_code;
    // Address that the next accepted legal word will be written to
    logic [ADDR_W-1:0] r_cnt;

    logic        w_accept;
    logic        w_legal;
    logic [31:0] w_inst;
    err_e        w_err;
    logic        w_i_ok;
    logic        w_d_ok;
    logic        w_cb_ok;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_legal   = (w_err == ERR_NONE);

    // Immediate range checks: I is 12-bit unsigned, D and CB are sign-extended
    assign w_i_ok  = (in_imm[25:12] == '0);
    assign w_d_ok  = (in_imm[25:8]  == {18{in_imm[8]}});
    assign w_cb_ok = (in_imm[25:18] == {8{in_imm[18]}});

    // Encode the request and classify it as legal, illegal op or range error
    always_comb begin
        w_inst = '0;
        w_err  = ERR_NONE;
        case (in_op)
            5'd0:  w_inst = enc_r(OPC_ADD,  in_rm, in_shamt, in_rn, in_rd);
            5'd1:  w_inst = enc_r(OPC_ADDS, in_rm, in_shamt, in_rn, in_rd);
            5'd2:  w_inst = enc_r(OPC_SUB,  in_rm, in_shamt, in_rn, in_rd);
            5'd3:  w_inst = enc_r(OPC_SUBS, in_rm, in_shamt, in_rn, in_rd);
            5'd4:  w_inst = enc_r(OPC_AND,  in_rm, in_shamt, in_rn, in_rd);
            5'd5:  w_inst = enc_r(OPC_ANDS, in_rm, in_shamt, in_rn, in_rd);
            5'd6:  w_inst = enc_r(OPC_ORR,  in_rm, in_shamt, in_rn, in_rd);
            5'd7:  w_inst = enc_r(OPC_EOR,  in_rm, in_shamt, in_rn, in_rd);
            // Shifts take no second register operand
            5'd8:  w_inst = enc_r(OPC_LSR,  5'd0,  in_shamt, in_rn, in_rd);
            5'd9:  w_inst = enc_r(OPC_LSL,  5'd0,  in_shamt, in_rn, in_rd);
            5'd10: begin
                w_inst = enc_d(OPC_LDUR, in_imm[8:0], in_rn, in_rd);
                if (!w_d_ok) w_err = ERR_RANGE;
            end
            5'd11: begin
                w_inst = enc_d(OPC_STUR, in_imm[8:0], in_rn, in_rd);
                if (!w_d_ok) w_err = ERR_RANGE;
            end
            5'd12: begin
                w_inst = enc_i(OPC_ADDI,  in_imm[11:0], in_rn, in_rd);
                if (!w_i_ok) w_err = ERR_RANGE;
            end
            5'd13: begin
                w_inst = enc_i(OPC_ANDI,  in_imm[11:0], in_rn, in_rd);
                if (!w_i_ok) w_err = ERR_RANGE;
            end
            5'd14: begin
                w_inst = enc_i(OPC_ORRI,  in_imm[11:0], in_rn, in_rd);
                if (!w_i_ok) w_err = ERR_RANGE;
            end
            5'd15: begin
                w_inst = enc_i(OPC_SUBI,  in_imm[11:0], in_rn, in_rd);
                if (!w_i_ok) w_err = ERR_RANGE;
            end
            5'd16: begin
                w_inst = enc_i(OPC_EORI,  in_imm[11:0], in_rn, in_rd);
                if (!w_i_ok) w_err = ERR_RANGE;
            end
            5'd17: begin
                w_inst = enc_i(OPC_ADDIS, in_imm[11:0], in_rn, in_rd);
                if (!w_i_ok) w_err = ERR_RANGE;
            end
            5'd18: begin
                w_inst = enc_i(OPC_SUBIS, in_imm[11:0], in_rn, in_rd);
                if (!w_i_ok) w_err = ERR_RANGE;
            end
            5'd19: begin
                w_inst = enc_i(OPC_ANDIS, in_imm[11:0], in_rn, in_rd);
                if (!w_i_ok) w_err = ERR_RANGE;
            end
            5'd20: w_inst = {OPC_B, in_imm};
            5'd21: begin
                w_inst = enc_cb(OPC_CBZ,  in_imm[18:0], in_rd);
                if (!w_cb_ok) w_err = ERR_RANGE;
            end
            5'd22: begin
                w_inst = enc_cb(OPC_CBNZ, in_imm[18:0], in_rd);
                if (!w_cb_ok) w_err = ERR_RANGE;
            end
            default: w_err = ERR_ILLEGAL;
        endcase
    end

    // Output register: load on a legal accept, drain on a handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_addr  <= '0;
        end else if (w_accept && w_legal) begin
            r_out_valid <= 1'b1;
            r_out_inst  <= w_inst;
            r_out_addr  <= r_cnt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Error pulse: exactly one cycle per rejected request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_err_valid <= w_accept && !w_legal;
            r_err_code  <= (w_accept && !w_legal) ? w_err : ERR_NONE;
        end
    end

    // Address counter: a word takes its address when it enters the stage, so a
    // load while a word is held only affects the words that follow it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (addr_load) begin
            r_cnt <= addr_val;
        end else if (w_accept && w_legal) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_addr  = r_out_addr;
    assign err_valid = r_err_valid;
    assign err_code  = r_err_code;

endmodule
